// File: rtl/exec_pkg.sv
// Shared constants for the execute slice.
//  ALU_*  : 3-bit ALUControl operation codes
//  IMM_*  : 2-bit ImmSrc immediate format codes
package exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/enreg.sv
// Enable-gated D register with synchronous active-high reset.
//  clk    in   1      rising-edge clock
//  reset  in   1      synchronous, active-high; clears q and overrides en
//  en     in   1      load enable
//  d      in   WIDTH  data in
//  q      out  WIDTH  registered data
// REG_ID is a trace tag identifying the register instance; it has no
// functional effect.
module enreg #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] REG_ID = 3'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Tag kept visible in the netlist for trace tools; intentionally unread.
    logic [2:0] unused_tag;
    assign unused_tag = REG_ID;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute slice of the multi-cycle RV32 datapath: immediate sign-extender,
// ALU and the enable-gated ALUOut result register.
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high (clears ALUOut)
//  Instr       in   25     instruction bits [31:7]; Instr[k-7] = instruction bit k
//  ImmSrc      in   2      immediate format select (I/S/B/J)
//  SrcA        in   WIDTH  ALU operand A
//  RegB        in   WIDTH  register operand for B
//  BSel        in   1      0: B = RegB, 1: B = ImmExt
//  ALUControl  in   3      ALU operation select
//  OutWrite    in   1      load enable for ALUOut
//  ImmExt      out  WIDTH  sign-extended immediate (combinational)
//  ALUResult   out  WIDTH  ALU result (combinational)
//  Zero        out  1      ALUResult == 0 (combinational)
//  ALUOut      out  WIDTH  ALUResult registered one cycle later
module exec_stage
    import exec_pkg::*;
#(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] REG_ID = 3'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [24:0]      Instr,
    input  logic [1:0]       ImmSrc,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] RegB,
    input  logic             BSel,
    input  logic [2:0]       ALUControl,
    input  logic             OutWrite,
    output logic [WIDTH-1:0] ImmExt,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] ALUOut
);

    // Signed less-than, result zero-extended to the datapath width.
    function automatic logic [WIDTH-1:0] slt_signed(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return (a < b) ? WIDTH'(1) : '0;
    endfunction

    logic [31:0]      imm32_p0;
    logic [WIDTH-1:0] imm_ext_p0;
    logic [WIDTH-1:0] src_b_p0;
    logic [4:0]       shamt_p0;
    logic [WIDTH-1:0] alu_result_p0;
    logic [WIDTH-1:0] aluout_p1;

    // ---- stage p0: immediate extension, operand select, ALU (combinational)

    // Instr[k-7] carries instruction bit k, so bit 31 is Instr[24].
    always_comb begin
        imm32_p0 = '0;
        case (ImmSrc)
            IMM_I:   imm32_p0 = {{20{Instr[24]}}, Instr[24:13]};
            IMM_S:   imm32_p0 = {{20{Instr[24]}}, Instr[24:18], Instr[4:0]};
            IMM_B:   imm32_p0 = {{20{Instr[24]}}, Instr[0], Instr[23:18],
                                 Instr[4:1], 1'b0};
            IMM_J:   imm32_p0 = {{12{Instr[24]}}, Instr[12:5], Instr[13],
                                 Instr[23:14], 1'b0};
            default: imm32_p0 = '0;
        endcase
    end

    // The formats are defined at 32 bits; a signed cast widens to WIDTH.
    assign imm_ext_p0 = WIDTH'($signed(imm32_p0));

    assign src_b_p0 = BSel ? imm_ext_p0 : RegB;
    assign shamt_p0 = src_b_p0[4:0];

    always_comb begin
        alu_result_p0 = '0;
        case (ALUControl)
            ALU_ADD: alu_result_p0 = SrcA + src_b_p0;
            ALU_SUB: alu_result_p0 = SrcA - src_b_p0;
            ALU_AND: alu_result_p0 = SrcA & src_b_p0;
            ALU_OR:  alu_result_p0 = SrcA | src_b_p0;
            ALU_XOR: alu_result_p0 = SrcA ^ src_b_p0;
            ALU_SLT: alu_result_p0 = slt_signed(SrcA, src_b_p0);
            ALU_SLL: alu_result_p0 = SrcA << shamt_p0;
            ALU_SRL: alu_result_p0 = SrcA >> shamt_p0;
            default: alu_result_p0 = '0;
        endcase
    end

    assign ImmExt    = imm_ext_p0;
    assign ALUResult = alu_result_p0;
    assign Zero      = (alu_result_p0 == '0);

    // ---- stage p1: ALUOut result register

    enreg #(
        .WIDTH  (WIDTH),
        .REG_ID (REG_ID)
    ) u_aluout (
        .clk   (clk),
        .reset (reset),
        .en    (OutWrite),
        .d     (alu_result_p0),
        .q     (aluout_p1)
    );

    assign ALUOut = aluout_p1;

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage.
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] Instr;
    logic [1:0]  ImmSrc;
    logic [31:0] SrcA;
    logic [31:0] RegB;
    logic        BSel;
    logic [2:0]  ALUControl;
    logic        OutWrite;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] ALUOut;

    int tests_run    = 0;
    int tests_failed = 0;

    exec_stage #(.WIDTH(32), .REG_ID(3'd2)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ImmSrc     (ImmSrc),
        .SrcA       (SrcA),
        .RegB       (RegB),
        .BSel       (BSel),
        .ALUControl (ALUControl),
        .OutWrite   (OutWrite),
        .ImmExt     (ImmExt),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .ALUOut     (ALUOut)
    );

    always #5 clk = ~clk;

    task automatic set_instr(input logic [31:0] w);
        Instr = w[31:7];
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; OutWrite = 1'b1; BSel = 1'b0; ImmSrc = 2'b00;
        set_instr(32'h0000_0013);
        SrcA = 32'h0000_1234; RegB = 32'h0; ALUControl = 3'b000;
        tick();
        tests_run++;
        if (ALUOut !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_aluout: got %h expected %h", ALUOut, 32'h0);
        end
        tests_run++;
        if (ALUResult !== 32'h1234) begin
            tests_failed++;
            $display("FAIL reset_aluresult: got %h expected %h", ALUResult, 32'h1234);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (ALUOut !== 32'h1234) begin
            tests_failed++;
            $display("FAIL reset_release_load: got %h expected %h", ALUOut, 32'h1234);
        end
    endtask

    task automatic test_hold();
        SrcA = 32'd5; RegB = 32'd0; BSel = 1'b0; ALUControl = 3'b000; OutWrite = 1'b1;
        tick();
        tests_run++;
        if (ALUOut !== 32'd5) begin
            tests_failed++;
            $display("FAIL hold_load5: got %h expected %h", ALUOut, 32'd5);
        end
        OutWrite = 1'b0; SrcA = 32'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (ALUOut !== 32'd5) begin
                tests_failed++;
                $display("FAIL hold_edge%0d: got %h expected %h", i, ALUOut, 32'd5);
            end
        end
        tests_run++;
        if (ALUResult !== 32'd9) begin
            tests_failed++;
            $display("FAIL hold_aluresult: got %h expected %h", ALUResult, 32'd9);
        end
    endtask

    task automatic test_add_sub();
        SrcA = 32'd7; RegB = 32'd7; BSel = 1'b0; OutWrite = 1'b0;
        ALUControl = 3'b001;
        #1;
        tests_run++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_7_7: got %h/%b expected %h/%b", ALUResult, Zero, 32'd0, 1'b1);
        end
        ALUControl = 3'b000;
        #1;
        tests_run++;
        if (ALUResult !== 32'd14 || Zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_7_7: got %h/%b expected %h/%b", ALUResult, Zero, 32'd14, 1'b0);
        end
        SrcA = 32'h7FFF_FFFF; RegB = 32'd1;
        #1;
        tests_run++;
        if (ALUResult !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL add_wrap: got %h expected %h", ALUResult, 32'h8000_0000);
        end
        SrcA = 32'd0; RegB = 32'd1; ALUControl = 3'b001;
        #1;
        tests_run++;
        if (ALUResult !== 32'hFFFF_FFFF || Zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_0_1: got %h/%b expected %h/%b", ALUResult, Zero, 32'hFFFF_FFFF, 1'b0);
        end
    endtask

    task automatic test_logic();
        SrcA = 32'hF0F0_1234; RegB = 32'h0FF0_00FF; BSel = 1'b0;
        ALUControl = 3'b010;
        #1;
        tests_run++;
        if (ALUResult !== 32'h00F0_0034) begin
            tests_failed++;
            $display("FAIL and: got %h expected %h", ALUResult, 32'h00F0_0034);
        end
        ALUControl = 3'b011;
        #1;
        tests_run++;
        if (ALUResult !== 32'hFFF0_12FF) begin
            tests_failed++;
            $display("FAIL or: got %h expected %h", ALUResult, 32'hFFF0_12FF);
        end
        ALUControl = 3'b100;
        #1;
        tests_run++;
        if (ALUResult !== 32'hFF00_12CB) begin
            tests_failed++;
            $display("FAIL xor: got %h expected %h", ALUResult, 32'hFF00_12CB);
        end
    endtask

    task automatic test_extend();
        set_instr(32'hFFF0_0093); ImmSrc = 2'b00;
        #1;
        tests_run++;
        if (ImmExt !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL ext_i: got %h expected %h", ImmExt, 32'hFFFF_FFFF);
        end
        set_instr(32'hFE00_0EE3); ImmSrc = 2'b10;
        #1;
        tests_run++;
        if (ImmExt !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL ext_b: got %h expected %h", ImmExt, 32'hFFFF_FFFC);
        end
        ImmSrc = 2'b01;
        #1;
        tests_run++;
        if (ImmExt !== 32'hFFFF_FFFD) begin
            tests_failed++;
            $display("FAIL ext_s: got %h expected %h", ImmExt, 32'hFFFF_FFFD);
        end
        ImmSrc = 2'b11;
        #1;
        tests_run++;
        if (ImmExt !== 32'hFFF0_07E0) begin
            tests_failed++;
            $display("FAIL ext_j: got %h expected %h", ImmExt, 32'hFFF0_07E0);
        end
        set_instr(32'h0040_0093); ImmSrc = 2'b00;
        #1;
        tests_run++;
        if (ImmExt !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL ext_i_pos: got %h expected %h", ImmExt, 32'h0000_0004);
        end
    endtask

    task automatic test_cmp_shift();
        BSel = 1'b0; ALUControl = 3'b101;
        SrcA = 32'h8000_0000; RegB = 32'd1;
        #1;
        tests_run++;
        if (ALUResult !== 32'd1) begin
            tests_failed++;
            $display("FAIL slt_neg_1: got %h expected %h", ALUResult, 32'd1);
        end
        RegB = 32'd0;
        #1;
        tests_run++;
        if (ALUResult !== 32'd1) begin
            tests_failed++;
            $display("FAIL slt_neg_0: got %h expected %h", ALUResult, 32'd1);
        end
        SrcA = 32'd1; RegB = 32'h8000_0000;
        #1;
        tests_run++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL slt_pos_neg: got %h/%b expected %h/%b", ALUResult, Zero, 32'd0, 1'b1);
        end
        ALUControl = 3'b110; SrcA = 32'd1; RegB = 32'h21;
        #1;
        tests_run++;
        if (ALUResult !== 32'd2) begin
            tests_failed++;
            $display("FAIL sll_1_by_0x21: got %h expected %h", ALUResult, 32'd2);
        end
        ALUControl = 3'b111; SrcA = 32'h8000_0000; RegB = 32'd31;
        #1;
        tests_run++;
        if (ALUResult !== 32'd1) begin
            tests_failed++;
            $display("FAIL srl_msb_by_31: got %h expected %h", ALUResult, 32'd1);
        end
    endtask

    task automatic test_imm_path();
        BSel = 1'b1; SrcA = 32'h100; RegB = 32'hDEAD_BEEF;
        set_instr(32'h0040_0093); ImmSrc = 2'b00; ALUControl = 3'b000;
        OutWrite = 1'b1;
        #1;
        tests_run++;
        if (ALUResult !== 32'h104) begin
            tests_failed++;
            $display("FAIL imm_path_result: got %h expected %h", ALUResult, 32'h104);
        end
        tick();
        tests_run++;
        if (ALUOut !== 32'h104) begin
            tests_failed++;
            $display("FAIL imm_path_aluout: got %h expected %h", ALUOut, 32'h104);
        end
        OutWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Instr = '0; ImmSrc = 2'b00; SrcA = '0; RegB = '0;
        BSel = 1'b0; ALUControl = 3'b000; OutWrite = 1'b0;
        #2;
        test_reset();
        test_hold();
        test_add_sub();
        test_logic();
        test_extend();
        test_cmp_shift();
        test_imm_path();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
